regfile_mp: RTL and testbench

Parametrised successor to the single-write register file. It provides NUM_RD combinational read ports and two write ports: port 0 for ALU writeback and port 1 for load writeback. It also has optional write-to-read bypass and a per-register pending scoreboard for load-use hazard detection. On synchronous reset, a hardware clear sequencer sweeps the array to zero. It sits between decode (reads) and writeback (writes) in the core pipeline.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int MAX_NUM_RD = 4;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for load-use hazard detection, with per-port lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     act,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rpend
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] pending;

  // Set is applied after clear so a same-cycle reservation keeps the bit high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en) pending[set_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              fwd_clr;
    logic              is_zero;

    assign ra      = raddr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (ra == '0);
    assign fwd_clr = (BYPASS != 0) && clr_en && (clr_addr == ra)
                     && !(set_en && (set_addr == ra));
    assign rpend[k] = act && !is_zero && pending[ra] && !fwd_clr;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, ALU and load write ports,
// optional write-to-read bypass, pending scoreboard and a post-reset clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend
);

  localparam int DEPTH = depth_of(ADDR_W);

  if (NUM_RD < 1 || NUM_RD > MAX_NUM_RD) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD out of range");
  end

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic act;
  logic w0_en;
  logic w1_en;
  logic rsv_ok;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Reset masks everything combinationally so outputs read zero for its whole duration.
  assign act    = (state == READY) && !rst;
  assign ready  = act;
  assign w0_en  = act && we0 && writable(waddr0);
  assign w1_en  = act && we1 && writable(waddr1);
  assign rsv_ok = act && rsv_en && writable(rsv_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_ptr == '1) state_nxt = READY;
  end

  // Port 1 (load) wins an address conflict, so port 0 is suppressed on a match.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        if (w0_en && !(w1_en && waddr1 == waddr0)) mem[waddr0] <= wdata0;
        if (w1_en) mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem[ra];
      if (BYPASS != 0) begin
        if (w0_en && waddr0 == ra) rd = wdata0;
        if (w1_en && waddr1 == ra) rd = wdata1;
      end
      if (!act || ((ZERO_REG != 0) && ra == '0)) rd = '0;
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .act     (act),
    .set_en  (rsv_ok),
    .set_addr(rsv_addr),
    .clr_en  (w1_en),
    .clr_addr(waddr1),
    .raddr   (raddr),
    .rpend   (rpend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances share stimulus and are
// compared every cycle against an array-based model, plus directed literal checks.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     we0, we1, rsv_en;
  logic [ADDR_W-1:0]        waddr0, waddr1, rsv_addr;
  logic [DATA_W-1:0]        wdata0, wdata1;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic                     ready_b, ready_n;
  logic [NUM_RD*DATA_W-1:0] rdata_b, rdata_n;
  logic [NUM_RD-1:0]        rpend_b, rpend_n;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ready(ready_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr(raddr), .rdata(rdata_b), .rpend(rpend_b)
  );

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ready(ready_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .raddr(raddr), .rdata(rdata_n), .rpend(rpend_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain array of register values, pending flags and a sweep counter.
  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                pend_m [DEPTH];
  bit                ready_m = 1'b0;
  int                sweep_m = 0;
  bit                chk_on  = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) begin
    mem_m[i]  = '0;
    pend_m[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      chk_on  <= 1'b1;
      ready_m <= 1'b0;
      sweep_m <= 0;
      for (int i = 0; i < DEPTH; i++) pend_m[i] <= 1'b0;
    end else if (!ready_m) begin
      mem_m[sweep_m] <= '0;
      sweep_m        <= sweep_m + 1;
      if (sweep_m == DEPTH - 1) ready_m <= 1'b1;
    end else begin
      if (we0 && waddr0 != 0) mem_m[waddr0] <= wdata0;
      if (we1 && waddr1 != 0) mem_m[waddr1] <= wdata1;
      if (we1 && waddr1 != 0) pend_m[waddr1] <= 1'b0;
      if (rsv_en && rsv_addr != 0) pend_m[rsv_addr] <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] exp_rdata(input logic [ADDR_W-1:0] ra, input bit byp);
    if (!ready_m || rst || ra == 0) return '0;
    if (byp && we1 && waddr1 == ra) return wdata1;
    if (byp && we0 && waddr0 == ra) return wdata0;
    return mem_m[ra];
  endfunction

  function automatic logic exp_rpend(input logic [ADDR_W-1:0] ra, input bit byp);
    if (!ready_m || rst || ra == 0) return 1'b0;
    if (byp && we1 && waddr1 == ra && !(rsv_en && rsv_addr == ra)) return 1'b0;
    return pend_m[ra];
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("ready_byp", 32'(ready_b), 32'(ready_m && !rst));
      check("ready_nobyp", 32'(ready_n), 32'(ready_m && !rst));
      for (int k = 0; k < NUM_RD; k++) begin
        logic [ADDR_W-1:0] ra;
        ra = raddr[k*ADDR_W +: ADDR_W];
        check("rdata_byp", rdata_b[k*DATA_W +: DATA_W], exp_rdata(ra, 1'b1));
        check("rdata_nobyp", rdata_n[k*DATA_W +: DATA_W], exp_rdata(ra, 1'b0));
        check("rpend_byp", 32'(rpend_b[k]), 32'(exp_rpend(ra, 1'b1)));
        check("rpend_nobyp", 32'(rpend_n[k]), 32'(exp_rpend(ra, 1'b0)));
      end
    end
  end

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_b && n < 40) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; idle();
    waddr0 = '0; waddr1 = '0; rsv_addr = '0;
    wdata0 = '0; wdata1 = '0; raddr = '0;
    step(); step();
    @(negedge clk); check("reset_ready", 32'(ready_b), 32'd0);
    rst = 1'b0;
    wait_ready(n);
    check("first_sweep_len", n, 32'd32);

    // Preload entry 7, then pulse reset and confirm the sweep wiped it.
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hDEADBEEF;
    step(); idle();
    raddr[4:0] = 5'd7;
    @(negedge clk); check("preload_read", rdata_b[31:0], 32'hDEADBEEF);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk); check("clear_rdata", rdata_b[31:0], 32'd0);
    wait_ready(n);
    check("pulse_sweep_len", n, 32'd32);
    @(negedge clk); check("cleared_entry7", rdata_n[31:0], 32'h00000000);

    // Same-address dual write: load port wins.
    step();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h11111111;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h22222222;
    step(); idle();
    raddr[4:0] = 5'd5;
    @(negedge clk);
    check("conflict_byp", rdata_b[31:0], 32'h22222222);
    check("conflict_nobyp", rdata_n[31:0], 32'h22222222);

    // Bypass: same-cycle forwarding only in the BYPASS=1 instance.
    step();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
    raddr[9:5] = 5'd3;
    @(negedge clk);
    check("bypass_same_cycle", rdata_b[63:32], 32'hA5A5A5A5);
    check("nobypass_old_value", rdata_n[63:32], 32'h00000000);
    step(); idle();
    @(negedge clk); check("nobypass_next_cycle", rdata_n[63:32], 32'hA5A5A5A5);

    // Zero register ignores writes and reservations.
    step();
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    raddr[4:0] = 5'd0;
    @(negedge clk); check("zero_same_cycle", rdata_b[31:0], 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(); idle();
      @(negedge clk);
      check("zero_rdata", rdata_b[31:0], 32'd0);
      check("zero_rpend", 32'(rpend_b[0]), 32'd0);
    end

    // Scoreboard set / same-cycle set+clear / clear.
    step();
    rsv_en = 1'b1; rsv_addr = 5'd9; raddr[4:0] = 5'd9;
    step(); idle();
    @(negedge clk); check("rsv_pending", 32'(rpend_b[0]), 32'd1);
    step();
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h00000099;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    @(negedge clk); check("rsv_wins_same_cycle", 32'(rpend_b[0]), 32'd1);
    step(); idle();
    @(negedge clk); check("rsv_wins_after", 32'(rpend_n[0]), 32'd1);
    step();
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h00000077;
    @(negedge clk);
    check("clr_bypass_rpend", 32'(rpend_b[0]), 32'd0);
    check("clr_nobypass_rpend", 32'(rpend_n[0]), 32'd1);
    step(); idle();
    @(negedge clk);
    check("cleared_pending", 32'(rpend_n[0]), 32'd0);
    check("load_data", rdata_n[31:0], 32'h00000077);

    // Mid-sweep reset with writes attempted throughout the sweep.
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h12345678;
    we1 = 1'b1; waddr1 = 5'd13; wdata1 = 32'h87654321;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step(); rst = 1'b0;
    wait_ready(n);
    idle();
    check("restart_sweep_len", n, 32'd32);
    raddr = {5'd13, 5'd12};
    @(negedge clk);
    check("clear_write_ignored0", rdata_b[31:0], 32'd0);
    check("clear_write_ignored1", rdata_b[63:32], 32'd0);
    check("clear_rsv_ignored", 32'(rpend_b[0]), 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst      = ($urandom_range(0, 299) == 0);
      we0      = $urandom_range(0, 1);
      we1      = $urandom_range(0, 1);
      rsv_en   = ($urandom_range(0, 2) == 0);
      waddr0   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      waddr1   = 5'($urandom_range(0, 7));
      rsv_addr = 5'($urandom_range(0, 7));
      wdata0   = $urandom;
      wdata1   = $urandom;
      raddr    = {5'($urandom_range(0, 7)), 5'($urandom)};
    end
    step(); idle(); rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
